// File: rtl/alu_pkg.sv
// Shared definitions for the decode/issue stage and the ALU it feeds:
// opcodes, shift controls, instruction field positions and the issue bundle.
package alu_pkg;

  localparam int ALU_DW = 32;
  localparam int REG_W  = 4;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_MOVI = 4'b0110;
  localparam logic [3:0] OP_MOV  = 4'b0111;
  localparam logic [3:0] OP_LDR  = 4'b1101;
  localparam logic [3:0] OP_STR  = 4'b1110;

  localparam logic [2:0] SR_NONE = 3'b000;
  localparam logic [2:0] SR_LSR  = 3'b001;
  localparam logic [2:0] SR_LSL  = 3'b010;
  localparam logic [2:0] SR_ROR  = 3'b011;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int S_POS  = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 23;
  localparam int RN_HI  = 22;
  localparam int RN_LO  = 19;
  localparam int RM_HI  = 18;
  localparam int RM_LO  = 15;
  localparam int SRC_HI = 14;
  localparam int SRC_LO = 12;
  localparam int SRB_HI = 11;
  localparam int SRB_LO = 7;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef struct packed {
    logic [ALU_DW-1:0] in1;
    logic [ALU_DW-1:0] in2;
    logic [3:0]        opcode;
    logic [4:0]        sr_bit;
    logic [2:0]        sr_cont;
    logic              s;
    logic [15:0]       immediate;
    logic [REG_W-1:0]  rd;
    logic              wr_en;
  } ex_bundle_t;

endpackage

// File: rtl/decode_issue_reg_file.sv
// NREG x DW register file: three asynchronous read ports, one synchronous
// write port, and a write-to-read bypass so a retiring value is seen immediately.
module reg_file #(
  parameter int NREG = 16,
  parameter int DW   = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] ra_b,
  output logic [DW-1:0] rdata_b,
  input  logic [AW-1:0] ra_c,
  output logic [DW-1:0] rdata_c
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rdata_a = (we && (wa == ra_a)) ? wd : mem[ra_a];
  assign rdata_b = (we && (wa == ra_b)) ? wd : mem[ra_b];
  assign rdata_c = (we && (wa == ra_c)) ? wd : mem[ra_c];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes one instruction per cycle, reads operands, stalls on
// RAW/WAW hazards via a pending-register scoreboard and registers the ALU bundle.
module decode_issue
  import alu_pkg::*;
#(
  parameter int NREG = 16,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Instr_Valid,
  output logic          Instr_Ready,
  input  logic [31:0]   Instr,
  output logic          Ex_Valid,
  input  logic          Ex_Ready,
  output logic [DW-1:0] In1,
  output logic [DW-1:0] In2,
  output logic [3:0]    Opcode,
  output logic [4:0]    SR_Bit,
  output logic [2:0]    SR_Cont,
  output logic          S,
  output logic [15:0]   Immediate,
  output logic [3:0]    Ex_Rd,
  output logic          Ex_WrEn,
  input  logic          Wb_Valid,
  input  logic [3:0]    Wb_Rd,
  input  logic [DW-1:0] Wb_Data,
  output logic          Illegal
);

  logic [3:0]      op, rd, rn, rm;
  logic [2:0]      sr_cont;
  logic [4:0]      sr_bit;
  logic [15:0]     imm;
  logic            s_bit;
  logic            legal, use_rn, use_rm, use_rd, wr_en, is_movi;
  logic            hz, free, accept, issue;
  logic [DW-1:0]   rdata_a, rdata_b, rdata_c;
  logic [NREG-1:0] pending, pending_nxt;
  ex_bundle_t      bundle_nxt, bundle_p1;
  logic            vld_p1, illegal_p1;

  // A pending register only blocks if it is not retiring this very cycle.
  function automatic logic blocked(input logic [NREG-1:0] pend, input logic [3:0] r,
                                   input logic wv, input logic [3:0] wr);
    return pend[r] & ~(wv & (wr == r));
  endfunction

  assign op      = Instr[OPC_HI:OPC_LO];
  assign s_bit   = Instr[S_POS];
  assign rd      = Instr[RD_HI:RD_LO];
  assign rn      = Instr[RN_HI:RN_LO];
  assign rm      = Instr[RM_HI:RM_LO];
  assign sr_cont = Instr[SRC_HI:SRC_LO];
  assign sr_bit  = Instr[SRB_HI:SRB_LO];
  assign imm     = Instr[IMM_HI:IMM_LO];

  always_comb begin
    legal   = 1'b1;
    use_rn  = 1'b0;
    use_rm  = 1'b0;
    use_rd  = 1'b0;
    wr_en   = 1'b0;
    is_movi = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
        use_rn = 1'b1;
        use_rm = 1'b1;
        wr_en  = 1'b1;
      end
      OP_MOVI: begin
        is_movi = 1'b1;
        wr_en   = 1'b1;
      end
      OP_MOV, OP_LDR: begin
        use_rn = 1'b1;
        wr_en  = 1'b1;
      end
      OP_STR: begin
        use_rn = 1'b1;
        use_rd = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  reg_file #(.NREG(NREG), .DW(DW), .AW(4)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (Wb_Valid),
    .wa      (Wb_Rd),
    .wd      (Wb_Data),
    .ra_a    (rn),
    .rdata_a (rdata_a),
    .ra_b    (rm),
    .rdata_b (rdata_b),
    .ra_c    (rd),
    .rdata_c (rdata_c)
  );

  // Illegal opcodes use no sources and write nothing, so they never see hz.
  assign hz = (use_rn & blocked(pending, rn, Wb_Valid, Wb_Rd))
            | (use_rm & blocked(pending, rm, Wb_Valid, Wb_Rd))
            | ((use_rd | wr_en) & blocked(pending, rd, Wb_Valid, Wb_Rd));

  assign free        = ~vld_p1 | Ex_Ready;
  assign Instr_Ready = free & ~hz;
  assign accept      = Instr_Valid & Instr_Ready;
  assign issue       = accept & legal;

  always_comb begin
    bundle_nxt           = '0;
    bundle_nxt.in1       = use_rn ? rdata_a : '0;
    bundle_nxt.in2       = use_rm ? rdata_b : (use_rd ? rdata_c : '0);
    bundle_nxt.opcode    = op;
    bundle_nxt.sr_bit    = sr_bit;
    bundle_nxt.sr_cont   = sr_cont;
    bundle_nxt.s         = s_bit;
    bundle_nxt.immediate = is_movi ? imm : 16'h0000;
    bundle_nxt.rd        = rd;
    bundle_nxt.wr_en     = wr_en;
  end

  // Retire first, then reserve, so a same-cycle reissue keeps the bit set.
  always_comb begin
    pending_nxt = pending;
    if (Wb_Valid) pending_nxt[Wb_Rd] = 1'b0;
    if (issue && wr_en) pending_nxt[rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  // Stage p1: registered bundle toward the ALU
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      bundle_p1  <= '0;
      illegal_p1 <= 1'b0;
    end else begin
      illegal_p1 <= accept & ~legal;
      if (issue) begin
        vld_p1    <= 1'b1;
        bundle_p1 <= bundle_nxt;
      end else if (Ex_Ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign Ex_Valid  = vld_p1;
  assign In1       = bundle_p1.in1;
  assign In2       = bundle_p1.in2;
  assign Opcode    = bundle_p1.opcode;
  assign SR_Bit    = bundle_p1.sr_bit;
  assign SR_Cont   = bundle_p1.sr_cont;
  assign S         = bundle_p1.s;
  assign Immediate = bundle_p1.immediate;
  assign Ex_Rd     = bundle_p1.rd;
  assign Ex_WrEn   = bundle_p1.wr_en;
  assign Illegal   = illegal_p1;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: issue, hazards, backpressure, MOVI/STR,
// illegal opcodes and reset, with hand-computed expectations.
module tb_decode_issue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic [31:0] Instr;
  logic        Ex_Valid;
  logic        Ex_Ready;
  logic [31:0] In1, In2;
  logic [3:0]  Opcode;
  logic [4:0]  SR_Bit;
  logic [2:0]  SR_Cont;
  logic        S;
  logic [15:0] Immediate;
  logic [3:0]  Ex_Rd;
  logic        Ex_WrEn;
  logic        Wb_Valid;
  logic [3:0]  Wb_Rd;
  logic [31:0] Wb_Data;
  logic        Illegal;

  int checks = 0;
  int errors = 0;

  decode_issue #(.NREG(16), .DW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .Instr_Valid (Instr_Valid),
    .Instr_Ready (Instr_Ready),
    .Instr       (Instr),
    .Ex_Valid    (Ex_Valid),
    .Ex_Ready    (Ex_Ready),
    .In1         (In1),
    .In2         (In2),
    .Opcode      (Opcode),
    .SR_Bit      (SR_Bit),
    .SR_Cont     (SR_Cont),
    .S           (S),
    .Immediate   (Immediate),
    .Ex_Rd       (Ex_Rd),
    .Ex_WrEn     (Ex_WrEn),
    .Wb_Valid    (Wb_Valid),
    .Wb_Rd       (Wb_Rd),
    .Wb_Data     (Wb_Data),
    .Illegal     (Illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic s, input logic [3:0] rd,
                                      input logic [3:0] rn, input logic [3:0] rm,
                                      input logic [2:0] sc, input logic [4:0] sb);
    return {op, s, rd, rn, rm, sc, sb, 7'b0};
  endfunction

  // Rn field deliberately non-zero so a MOVI that wrongly reads R1 is visible.
  function automatic logic [31:0] movi(input logic [3:0] rd, input logic [15:0] im);
    return {OP_MOVI, 1'b0, rd, 4'd1, 3'b000, im};
  endfunction

  initial begin
    rst = 1'b1; Instr_Valid = 1'b0; Instr = '0; Ex_Ready = 1'b1;
    Wb_Valid = 1'b0; Wb_Rd = '0; Wb_Data = '0;
    tick(); tick();
    chk("rst_ex_valid", Ex_Valid, 0);
    chk("rst_illegal", Illegal, 0);
    chk("rst_in1", In1, 0);
    rst = 1'b0; #1;
    chk("rst_instr_ready", Instr_Ready, 1);

    // Preload R1=15, R2=20, R7=77 (not pending: plain regfile writes)
    Wb_Valid = 1'b1; Wb_Rd = 4'd1; Wb_Data = 32'd15; tick();
    Wb_Rd = 4'd2; Wb_Data = 32'd20; tick();
    Wb_Rd = 4'd7; Wb_Data = 32'd77; tick();
    Wb_Valid = 1'b0;

    // ADD R3,R1,R2 with S=1, LSL by 5
    Instr = enc(OP_ADD, 1'b1, 4'd3, 4'd1, 4'd2, SR_LSL, 5'd5); Instr_Valid = 1'b1; #1;
    chk("add_ready", Instr_Ready, 1);
    tick();
    chk("add_ex_valid", Ex_Valid, 1);
    chk("add_in1", In1, 15);
    chk("add_in2", In2, 20);
    chk("add_opcode", Opcode, 4'h0);
    chk("add_rd", Ex_Rd, 3);
    chk("add_wren", Ex_WrEn, 1);
    chk("add_s", S, 1);
    chk("add_sr_cont", SR_Cont, 3'b010);
    chk("add_sr_bit", SR_Bit, 5);
    chk("add_imm", Immediate, 0);

    // SUB R4,R3,R1 back-to-back: RAW on R3
    Instr = enc(OP_SUB, 1'b0, 4'd4, 4'd3, 4'd1, SR_NONE, 5'd0); #1;
    chk("sub_raw_stall", Instr_Ready, 0);
    tick();
    chk("sub_add_drained", Ex_Valid, 0);
    chk("sub_still_stalled", Instr_Ready, 0);
    Wb_Valid = 1'b1; Wb_Rd = 4'd3; Wb_Data = 32'd35; #1;
    chk("sub_wb_release", Instr_Ready, 1);
    tick();
    Wb_Valid = 1'b0;
    chk("sub_ex_valid", Ex_Valid, 1);
    chk("sub_in1_bypass", In1, 35);
    chk("sub_in2", In2, 15);
    chk("sub_opcode", Opcode, 4'h1);
    chk("sub_rd", Ex_Rd, 4);

    // Backpressure: bundle holds for 3 cycles
    Ex_Ready = 1'b0;
    Instr = enc(OP_OR, 1'b0, 4'd6, 4'd1, 4'd2, SR_NONE, 5'd0); #1;
    chk("bp_not_ready", Instr_Ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", Ex_Valid, 1);
      chk("bp_hold_in1", In1, 35);
      chk("bp_hold_opcode", Opcode, 4'h1);
      chk("bp_hold_ready", Instr_Ready, 0);
    end
    Ex_Ready = 1'b1; #1;
    chk("bp_release_ready", Instr_Ready, 1);
    tick();
    chk("or_in1", In1, 15);
    chk("or_in2", In2, 20);
    chk("or_opcode", Opcode, 4'h3);
    chk("or_rd", Ex_Rd, 6);

    // MOVI R5,#60
    Instr = movi(4'd5, 16'd60); #1;
    chk("movi_ready", Instr_Ready, 1);
    tick();
    chk("movi_opcode", Opcode, 4'h6);
    chk("movi_imm", Immediate, 60);
    chk("movi_in1", In1, 0);
    chk("movi_in2", In2, 0);
    chk("movi_wren", Ex_WrEn, 1);
    chk("movi_rd", Ex_Rd, 5);

    // STR R7,[R2]
    Instr = enc(OP_STR, 1'b0, 4'd7, 4'd2, 4'd0, SR_NONE, 5'd0); #1;
    chk("str_ready", Instr_Ready, 1);
    tick();
    chk("str_opcode", Opcode, 4'hE);
    chk("str_in1_addr", In1, 20);
    chk("str_in2_data", In2, 77);
    chk("str_wren", Ex_WrEn, 0);
    chk("str_imm", Immediate, 0);

    // MOV R8,R7 (Rm field set but unused): R7 must not be pending after STR
    Instr = enc(OP_MOV, 1'b0, 4'd8, 4'd7, 4'd1, SR_NONE, 5'd0); #1;
    chk("str_no_pending_r7", Instr_Ready, 1);
    tick();
    chk("mov_opcode", Opcode, 4'h7);
    chk("mov_in1", In1, 77);
    chk("mov_in2", In2, 0);

    // WAW on R6, then retire+reissue R6 in the same cycle: set wins
    Instr = enc(OP_ADD, 1'b0, 4'd6, 4'd1, 4'd2, SR_NONE, 5'd0); #1;
    chk("waw_stall", Instr_Ready, 0);
    Wb_Valid = 1'b1; Wb_Rd = 4'd6; Wb_Data = 32'd99; #1;
    chk("waw_wb_release", Instr_Ready, 1);
    tick();
    Wb_Valid = 1'b0;
    chk("waw_rd", Ex_Rd, 6);
    Instr = enc(OP_ADD, 1'b0, 4'd9, 4'd6, 4'd1, SR_NONE, 5'd0); #1;
    chk("set_wins_stall", Instr_Ready, 0);

    // Illegal opcode 1111 (Rn=R4 pending, Rd=R11): accepted, pulses once
    Instr = enc(4'hF, 1'b0, 4'd11, 4'd4, 4'd1, SR_NONE, 5'd0); #1;
    chk("ill_ready", Instr_Ready, 1);
    tick();
    Instr_Valid = 1'b0;
    chk("ill_pulse", Illegal, 1);
    chk("ill_no_bundle", Ex_Valid, 0);
    tick();
    chk("ill_pulse_end", Illegal, 0);
    chk("ill_still_no_bundle", Ex_Valid, 0);
    Instr_Valid = 1'b1;
    Instr = enc(OP_ADD, 1'b0, 4'd10, 4'd4, 4'd1, SR_NONE, 5'd0); #1;
    chk("ill_pend4_kept", Instr_Ready, 0);
    Instr = enc(OP_ADD, 1'b0, 4'd12, 4'd11, 4'd1, SR_NONE, 5'd0); #1;
    chk("ill_no_set_r11", Instr_Ready, 1);
    Instr_Valid = 1'b0;

    // Reset while a bundle is held and R3 is pending
    tick();
    Ex_Ready = 1'b0; Instr_Valid = 1'b1;
    Instr = enc(OP_ADD, 1'b0, 4'd3, 4'd1, 4'd2, SR_NONE, 5'd0);
    tick();
    Instr_Valid = 1'b0;
    chk("pre_rst_valid", Ex_Valid, 1);
    chk("pre_rst_in1", In1, 15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_ex_valid", Ex_Valid, 0);
    chk("rst2_in1", In1, 0);
    chk("rst2_rd", Ex_Rd, 0);
    chk("rst2_wren", Ex_WrEn, 0);
    Ex_Ready = 1'b1; Instr_Valid = 1'b1;
    Instr = enc(OP_SUB, 1'b0, 4'd4, 4'd3, 4'd1, SR_NONE, 5'd0); #1;
    chk("rst2_pending_clear", Instr_Ready, 1);
    tick();
    chk("rst2_sub_valid", Ex_Valid, 1);
    chk("rst2_sub_in1", In1, 0);
    chk("rst2_sub_in2", In2, 0);
    Instr = enc(OP_ADD, 1'b0, 4'd8, 4'd7, 4'd2, SR_NONE, 5'd0); #1;
    chk("rst2_add_ready", Instr_Ready, 1);
    tick();
    Instr_Valid = 1'b0;
    chk("rst2_r7_cleared", In1, 0);
    chk("rst2_r2_cleared", In2, 0);
    tick();
    chk("final_drain", Ex_Valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
